// File: rtl/ddr_outbuf_if.sv
// Word-pair stream into the DDR output buffer: rise/fall halves with a valid/ready handshake.
interface ddr_outbuf_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] in_data_rise;
  logic [WIDTH-1:0] in_data_fall;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data_rise,
    output in_data_fall,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data_rise,
    input  in_data_fall,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ddr_outbuf.sv
// DDR transmit buffer: FIFO of word pairs serialized onto the pad bus with rise data on posedge,
// fall data on negedge, and an output enable framed by one preamble and one postamble cycle.
module ddr_outbuf #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  ddr_outbuf_if.slave              in_bus,
  output logic [WIDTH-1:0]         dq_rise,
  output logic [WIDTH-1:0]         dq_fall,
  output logic                     oe,
  output logic                     underrun,
  input  logic                     clear_underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] FullLevel = DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StPreamble, StRun, StPostamble} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_rise [DEPTH];
  logic [WIDTH-1:0] mem_fall [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             ready_q;

  logic [WIDTH-1:0] dq_rise_q, fall_stage_q, dq_fall_q;
  logic             oe_q, underrun_q;

  logic             empty, full, push, pop;
  logic [WIDTH-1:0] rise_d, fall_d;
  logic             oe_d, set_underrun;

  assign empty           = (level_q == '0);
  assign full            = (level_q == FullLevel);
  // ready_q holds in_ready low until the first edge after reset release
  assign in_bus.in_ready = ready_q & ~full;
  assign push            = in_bus.in_valid & in_bus.in_ready & ~flush;

  // Pad registers carry the action decided in the state held before the edge, so the
  // preamble and postamble each show up as exactly one oe=1 idle cycle around the data.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    rise_d       = IDLE_VALUE;
    fall_d       = IDLE_VALUE;
    oe_d         = 1'b0;
    set_underrun = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) state_d = StPreamble;
        end
        StPreamble: begin
          oe_d    = 1'b1;
          state_d = StRun;
        end
        StRun: begin
          oe_d = 1'b1;
          if (!empty) begin
            pop    = 1'b1;
            rise_d = mem_rise[rd_ptr_q];
            fall_d = mem_fall[rd_ptr_q];
          end else if (enable) begin
            set_underrun = 1'b1;
          end else begin
            state_d = StPostamble;
          end
        end
        StPostamble: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rise[wr_ptr_q] <= in_bus.in_data_rise;
      mem_fall[wr_ptr_q] <= in_bus.in_data_fall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        level_q <= level_q + LW'(push) - LW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dq_rise_q    <= IDLE_VALUE;
      fall_stage_q <= IDLE_VALUE;
      oe_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      dq_rise_q    <= rise_d;
      fall_stage_q <= fall_d;
      oe_q         <= oe_d;
      if (clear_underrun) begin
        underrun_q <= 1'b0;
      end else if (set_underrun) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Fall half trails its rise partner by half a cycle; reset still clears it asynchronously.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dq_fall_q <= IDLE_VALUE;
    end else begin
      dq_fall_q <= fall_stage_q;
    end
  end

  assign dq_rise  = dq_rise_q;
  assign dq_fall  = dq_fall_q;
  assign oe       = oe_q;
  assign underrun = underrun_q;
  assign level    = level_q;

endmodule

// File: tb/tb_ddr_outbuf.sv
// Scoreboard bench for ddr_outbuf: randomized pairs against a queue-based pad schedule model.
module tb_ddr_outbuf;
  localparam int unsigned      WIDTH = 16;
  localparam int unsigned      DEPTH = 4;
  localparam int unsigned      LW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] IDLE  = 16'h5A5A;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             flush = 1'b0;
  logic             clear_underrun = 1'b0;
  logic [WIDTH-1:0] dq_rise, dq_fall;
  logic             oe, underrun;
  logic [LW-1:0]    level;

  ddr_outbuf_if #(.WIDTH(WIDTH)) bus ();

  ddr_outbuf #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .IDLE_VALUE (IDLE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .flush          (flush),
    .in_bus         (bus),
    .dq_rise        (dq_rise),
    .dq_fall        (dq_fall),
    .oe             (oe),
    .underrun       (underrun),
    .clear_underrun (clear_underrun),
    .level          (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] f;
  } pair_t;

  typedef struct packed {
    logic             oe;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [LW-1:0]    lvl;
    logic             rdy;
    logic             ur;
  } exp_t;

  exp_t  exp_q[$];
  pair_t mq[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;

  // Model: mode 0 quiet, 1 bus turnaround, 2 streaming, 3 closing after the postamble cycle
  int               mode = 0;
  logic             m_oe = 1'b0;
  logic             m_ur = 1'b0;
  logic [WIDTH-1:0] m_rise = IDLE;
  logic [WIDTH-1:0] m_stage = IDLE;
  bit               m_live = 1'b0;
  bit               hold = 1'b0;
  pair_t            cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs after the next posedge, advances a cycle.
  task automatic step(input bit en, input bit fl, input bit v, input bit clr);
    pair_t p;
    exp_t  e;
    bit    rdy, hsk, acc;
    if (!hold) begin
      cur.r = WIDTH'($urandom);
      cur.f = WIDTH'($urandom);
    end
    enable             = en;
    flush              = fl;
    bus.in_valid       = v;
    bus.in_data_rise   = cur.r;
    bus.in_data_fall   = cur.f;
    clear_underrun     = clr;

    rdy = m_live && (mq.size() < DEPTH);
    hsk = v && rdy;
    acc = hsk && !fl;
    m_rise  = IDLE;
    m_stage = IDLE;
    if (fl) begin
      mq.delete();
      mode = 0;
      m_oe = 1'b0;
    end else begin
      case (mode)
        0: begin
          m_oe = 1'b0;
          if (en) mode = 1;
        end
        1: begin
          m_oe = 1'b1;
          mode = 2;
        end
        2: begin
          m_oe = 1'b1;
          if (mq.size() != 0) begin
            p = mq.pop_front();
            m_rise  = p.r;
            m_stage = p.f;
          end else if (en) begin
            m_ur = 1'b1;
          end else begin
            mode = 3;
          end
        end
        default: begin
          m_oe = 1'b0;
          mode = 0;
        end
      endcase
    end
    if (clr) m_ur = 1'b0;
    if (acc) mq.push_back(cur);
    m_live = 1'b1;
    hold   = v && !hsk;

    e.oe   = m_oe;
    e.rise = m_rise;
    e.fall = m_stage;
    e.lvl  = LW'(mq.size());
    e.rdy  = (mq.size() < DEPTH);
    e.ur   = m_ur;
    exp_q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("oe",       32'(oe),           32'(e.oe));
        chk("dq_rise",  32'(dq_rise),      32'(e.rise));
        chk("dq_fall",  32'(dq_fall),      32'(e.fall));
        chk("level",    32'(level),        32'(e.lvl));
        chk("in_ready", 32'(bus.in_ready), 32'(e.rdy));
        chk("underrun", 32'(underrun),     32'(e.ur));
      end
    end
  end

  initial begin : driver
    bus.in_valid     = 1'b0;
    bus.in_data_rise = '0;
    bus.in_data_fall = '0;
    #12;
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst oe",       32'(oe),           32'd0);
    chk("rst dq_rise",  32'(dq_rise),      32'(IDLE));
    chk("rst dq_fall",  32'(dq_fall),      32'(IDLE));
    chk("rst level",    32'(level),        32'd0);
    chk("rst underrun", 32'(underrun),     32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Back-to-back stream, then starve it to raise underrun, clear it, then close.
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);

    // Fill past capacity while disabled, then drain with the held pair following.
    repeat (6) step(0, 0, 1, 0);
    repeat (3) step(1, 0, 1, 0);
    repeat (6) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // Two queued pairs drained after enable drops, re-enable during postamble.
    repeat (2) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // Flush mid-stream with a concurrent push.
    repeat (4) step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0);

    repeat (400) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // Land in a streaming cycle, then assert reset between edges.
    step(1, 0, 0, 1);
    repeat (6) step(1, 0, 1, 0);
    mon_en = 1'b0;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("pre-reset oe", 32'(oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async dq_rise",  32'(dq_rise),      32'(IDLE));
    chk("async dq_fall",  32'(dq_fall),      32'(IDLE));
    chk("async oe",       32'(oe),           32'd0);
    chk("async level",    32'(level),        32'd0);
    chk("async in_ready", 32'(bus.in_ready), 32'd0);
    chk("async underrun", 32'(underrun),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
